multi_column_engine: RTL and testbench

MULTI_COLUMN_ENGINE -- requirements
Module: multi_column_engine

---
 rtl/multi_column_engine.sv | 206 ++++++++++++++++++++
 tb/tb_multi_column_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_column_engine.sv
// Falling-letter typing game: COLUMNS independent letter columns fall one row per tick.
// Optional macro SPEEDUP_EN shortens the tick period as the score grows.
module multi_column_engine #(
    parameter int COLUMNS      = 4,
    parameter int BOARD_HEIGHT = 21,
    parameter int DELAY_CYCLES = 50000000
) (
    input  logic                   clock,
    input  logic                   reset_signal,
    input  logic                   start,
    input  logic [7:0]             user_input,
    input  logic                   user_valid,
    output logic [5*COLUMNS-1:0]   ypos,
    output logic [8*COLUMNS-1:0]   letter,
    output logic [COLUMNS-1:0]     active,
    output logic                   correct,
    output logic [15:0]            score,
    output logic                   game_over
);

    localparam logic [4:0]  HEIGHT = 5'(BOARD_HEIGHT);
    localparam logic [25:0] DELAY  = 26'(DELAY_CYCLES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ypos_q   [COLUMNS];
    logic [4:0]  ypos_d   [COLUMNS];
    logic [7:0]  letter_q [COLUMNS];
    logic [7:0]  letter_d [COLUMNS];
    logic [COLUMNS-1:0] active_q, active_d;
    logic        correct_q, correct_d;
    logic [15:0] score_q, score_d;
    logic        game_over_q, game_over_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [25:0] tick_cnt_q, tick_cnt_d;
    logic [25:0] period_q, period_d;
    logic        seen_low_q, seen_low_d;

    logic        tick;
    logic        hit;
    logic        matched;
    logic        spawned;
    logic [25:0] next_period;

    function automatic logic [7:0] lfsr_letter(input logic [7:0] l);
        logic [4:0] v;
        v = (l[4:0] >= 5'd26) ? l[4:0] - 5'd26 : l[4:0];
        return 8'h41 + {3'b000, v};
    endfunction

`ifdef SPEEDUP_EN
    // Period halves every 8 points, capped at an 8x speedup.
    always_comb begin
        next_period = DELAY;
        if (score_q[15:3] >= 13'd3) begin
            next_period = DELAY >> 3;
        end else begin
            next_period = DELAY >> score_q[4:3];
        end
    end
`else
    always_comb begin
        next_period = DELAY;
    end
`endif

    always_comb begin
        state_d     = state_q;
        ypos_d      = ypos_q;
        letter_d    = letter_q;
        active_d    = active_q;
        correct_d   = 1'b0;
        score_d     = score_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick_cnt_d  = tick_cnt_q;
        period_d    = period_q;
        seen_low_d  = seen_low_q;
        matched     = 1'b0;
        spawned     = 1'b0;
        hit         = 1'b0;
        tick        = (state_q == PLAY) && (tick_cnt_q == period_q - 26'd1);

        for (int i = 0; i < COLUMNS; i++) begin
            if (active_q[i] && (ypos_q[i] == HEIGHT)) begin
                hit = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (start) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    active_d = '0;
                    period_d = DELAY;
                    for (int i = 0; i < COLUMNS; i++) begin
                        ypos_d[i]   = '0;
                        letter_d[i] = '0;
                    end
                end
            end
            PLAY: begin
                if (hit) begin
                    // Board freezes as it stood when the bottom was reached.
                    state_d    = OVER;
                    tick_cnt_d = '0;
                    seen_low_d = 1'b0;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 26'd1;
                    if (tick) begin
                        period_d = next_period;
                    end
                    if (user_valid) begin
                        for (int i = 0; i < COLUMNS; i++) begin
                            if (!matched && active_q[i] && (letter_q[i] == user_input)) begin
                                matched     = 1'b1;
                                active_d[i] = 1'b0;
                                ypos_d[i]   = '0;
                            end
                        end
                    end
                    if (matched) begin
                        correct_d = 1'b1;
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                    end
                    // Movement and spawn see the board after this clock's match.
                    if (tick) begin
                        for (int i = 0; i < COLUMNS; i++) begin
                            if (active_d[i]) begin
                                ypos_d[i] = ypos_q[i] + 5'd1;
                            end else if (!spawned) begin
                                spawned     = 1'b1;
                                active_d[i] = 1'b1;
                                ypos_d[i]   = '0;
                                letter_d[i] = lfsr_letter(lfsr_q);
                            end
                        end
                    end
                end
            end
            OVER: begin
                tick_cnt_d = '0;
                if (!start) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            state_q     <= IDLE;
            active_q    <= '0;
            correct_q   <= 1'b0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            lfsr_q      <= 8'h01;
            tick_cnt_q  <= '0;
            period_q    <= DELAY;
            seen_low_q  <= 1'b0;
            for (int i = 0; i < COLUMNS; i++) begin
                ypos_q[i]   <= '0;
                letter_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            correct_q   <= correct_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            lfsr_q      <= lfsr_d;
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            seen_low_q  <= seen_low_d;
            for (int i = 0; i < COLUMNS; i++) begin
                ypos_q[i]   <= ypos_d[i];
                letter_q[i] <= letter_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < COLUMNS; i++) begin
            ypos[5*i +: 5]   = ypos_q[i];
            letter[8*i +: 8] = letter_q[i];
        end
    end

    assign active    = active_q;
    assign correct   = correct_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_multi_column_engine.sv
// Directed table-driven bench for multi_column_engine (4 columns, height 3, 4-clock ticks).
module tb_multi_column_engine;

    localparam int COLS = 4;

    logic                clock;
    logic                reset_signal;
    logic                start;
    logic [7:0]          user_input;
    logic                user_valid;
    logic [5*COLS-1:0]   ypos;
    logic [8*COLS-1:0]   letter;
    logic [COLS-1:0]     active;
    logic                correct;
    logic [15:0]         score;
    logic                game_over;

    multi_column_engine #(
        .COLUMNS(COLS),
        .BOARD_HEIGHT(3),
        .DELAY_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset_signal(reset_signal),
        .start(start),
        .user_input(user_input),
        .user_valid(user_valid),
        .ypos(ypos),
        .letter(letter),
        .active(active),
        .correct(correct),
        .score(score),
        .game_over(game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference letter generator: x^8+x^6+x^5+x^4+1, seed 8'h01, steps every clock.
    logic [7:0] m_lfsr;
    always @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            m_lfsr <= 8'h01;
        end else begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic [7:0] letter_of(input logic [7:0] l);
        int v;
        v = int'(l) % 32;
        if (v > 25) v = v - 26;
        return 8'(65 + v);
    endfunction

    // key: 0 none, 1 press column 0's letter, 2 press a letter column 0 does not hold
    typedef struct {
        int          cyc;
        logic        st;
        int          key;
        int          spawn;
        logic [3:0]  act;
        logic [19:0] yp;
        logic        cor;
        logic [15:0] sc;
        logic        go;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_let [COLS];
    logic [7:0] pre_letter;
    int         n_checks;
    int         n_fail;

    function automatic logic [19:0] yv(input int y0, input int y1, input int y2, input int y3);
        return {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
    endfunction

    function automatic vec_t mk(input int cyc, input logic st, input int key, input int spawn,
                                input logic [3:0] act, input logic [19:0] yp, input logic cor,
                                input logic [15:0] sc, input logic go);
        vec_t v;
        v.cyc = cyc; v.st = st; v.key = key; v.spawn = spawn; v.act = act;
        v.yp = yp; v.cor = cor; v.sc = sc; v.go = go;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
        end
    endtask

    task automatic run_tbl();
        vec_t v;
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            for (int c = 0; c < v.cyc; c++) begin
                start      = v.st;
                user_valid = 1'b0;
                user_input = 8'h00;
                if (c == v.cyc - 1) begin
                    pre_letter = letter_of(m_lfsr);
                    if (v.key == 1) begin
                        user_valid = 1'b1;
                        user_input = exp_let[0];
                    end else if (v.key == 2) begin
                        user_valid = 1'b1;
                        user_input = (exp_let[0] == 8'h5A) ? 8'h41 : exp_let[0] + 8'd1;
                    end
                end
                @(posedge clock);
                @(negedge clock);
            end
            user_valid = 1'b0;
            if (v.spawn >= 0) exp_let[v.spawn] = pre_letter;
            check("active", r, 32'(active), 32'(v.act));
            check("ypos", r, 32'(ypos), 32'(v.yp));
            check("correct", r, 32'(correct), 32'(v.cor));
            check("score", r, 32'(score), 32'(v.sc));
            check("game_over", r, 32'(game_over), 32'(v.go));
            if (v.spawn >= 0) begin
                check("spawn_letter", r, 32'(letter[8*v.spawn +: 8]), 32'(exp_let[v.spawn]));
                check("letter_range", r, 32'(letter[8*v.spawn +: 8] >= 8'h41 && letter[8*v.spawn +: 8] <= 8'h5A), 32'd1);
            end
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_signal = 1'b0;
        start        = 1'b0;
        user_valid   = 1'b0;
        user_input   = 8'h00;
        for (int i = 0; i < COLS; i++) exp_let[i] = 8'h00;

        #12;
        check("rst_ypos", -1, 32'(ypos), 32'd0);
        check("rst_letter", -1, letter, 32'd0);
        check("rst_flags", -1, {27'd0, active, correct}, 32'd0);
        check("rst_score", -1, {16'd0, score}, 32'd0);
        @(negedge clock);
        reset_signal = 1'b1;

        // Game 1: spawn timing, unmatched and matched key, match coincident with tick,
        // bottom hit, frozen board, key ignored in OVER, restart clears score.
        tbl.push_back(mk(1, 1, 0, -1, 4'b0000, yv(0,0,0,0), 0, 0, 0));
        tbl.push_back(mk(4, 1, 0,  0, 4'b0001, yv(0,0,0,0), 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, -1, 4'b0001, yv(0,0,0,0), 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, -1, 4'b0000, yv(0,0,0,0), 1, 1, 0));
        tbl.push_back(mk(2, 1, 0,  0, 4'b0001, yv(0,0,0,0), 0, 1, 0));
        tbl.push_back(mk(4, 1, 0,  1, 4'b0011, yv(1,0,0,0), 0, 1, 0));
        tbl.push_back(mk(4, 1, 0,  2, 4'b0111, yv(2,1,0,0), 0, 1, 0));
        tbl.push_back(mk(4, 1, 1,  0, 4'b0111, yv(0,2,1,0), 1, 2, 0));
        tbl.push_back(mk(1, 1, 0, -1, 4'b0111, yv(0,2,1,0), 0, 2, 0));
        tbl.push_back(mk(3, 1, 0,  3, 4'b1111, yv(1,3,2,0), 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, -1, 4'b1111, yv(1,3,2,0), 0, 2, 1));
        tbl.push_back(mk(2, 0, 1, -1, 4'b1111, yv(1,3,2,0), 0, 2, 1));
        tbl.push_back(mk(1, 1, 0, -1, 4'b1111, yv(1,3,2,0), 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, -1, 4'b0000, yv(0,0,0,0), 0, 0, 0));
        // Game 2: build score to 5 before a mid-game reset.
        tbl.push_back(mk(4, 1, 0,  0, 4'b0001, yv(0,0,0,0), 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back(mk(1, 1, 1, -1, 4'b0000, yv(0,0,0,0), 1, 16'(k), 0));
            tbl.push_back(mk(3, 1, 0,  0, 4'b0001, yv(0,0,0,0), 0, 16'(k), 0));
        end
        tbl.push_back(mk(4, 1, 0,  1, 4'b0011, yv(1,0,0,0), 0, 5, 0));
        run_tbl();

        // Asynchronous mid-game reset, observed before any further clock edge.
        #2;
        reset_signal = 1'b0;
        start        = 1'b0;
        #1;
        check("mid_rst_ypos", -1, 32'(ypos), 32'd0);
        check("mid_rst_letter", -1, letter, 32'd0);
        check("mid_rst_active", -1, 32'(active), 32'd0);
        check("mid_rst_score", -1, {16'd0, score}, 32'd0);
        check("mid_rst_go_cor", -1, {30'd0, game_over, correct}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        check("held_rst_score", -1, {16'd0, score}, 32'd0);
        reset_signal = 1'b1;

        // Fresh game after reset: FSM back in IDLE, generator restarted from its seed.
        tbl.push_back(mk(2, 0, 0, -1, 4'b0000, yv(0,0,0,0), 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, -1, 4'b0000, yv(0,0,0,0), 0, 0, 0));
        tbl.push_back(mk(4, 1, 0,  0, 4'b0001, yv(0,0,0,0), 0, 0, 0));
        run_tbl();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
